// File: rtl/timetag_pkg.sv
// Shared types and constants for the timetag FX2 data path.
// Holds the serializer state encoding and the default frame marker byte.
package timetag_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        SEND = 2'd2
    } ser_state_t;

    localparam logic [7:0] DEFAULT_MARKER = 8'hA5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coinciding
// with clear leaves the counter at one so that event is not lost.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count register: reset, clear, saturating increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= inc ? W'(1) : W'(0);
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sample_serializer.sv
// Serializes show-ahead FIFO samples into bytes over a rdy/ack handshake,
// with optional in-band frame markers and a saturating sample counter.
module sample_serializer
    import timetag_pkg::*;
#(
    parameter int         SAMPLE_BYTES  = 6,
    parameter bit         LSB_FIRST     = 1'b1,
    parameter int         FRAME_SAMPLES = 0,
    parameter logic [7:0] MARKER        = DEFAULT_MARKER,
    parameter int         CNT_W         = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_rdy,
    input  logic [8*SAMPLE_BYTES-1:0] sample,
    output logic                      sample_ack,
    output logic                      data_rdy,
    output logic [7:0]                data,
    input  logic                      data_ack,
    input  logic                      count_clr,
    output logic [CNT_W-1:0]          sample_count
);

    localparam int IDX_W   = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam int FS_W    = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
    localparam int FS_LAST = (FRAME_SAMPLES > 0) ? FRAME_SAMPLES - 1 : 0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLE_BYTES - 1);

    ser_state_t                r_state;
    logic [8*SAMPLE_BYTES-1:0] r_shreg;
    logic [IDX_W-1:0]          r_byte_idx;
    logic [FS_W-1:0]           r_frame_cnt;
    logic [7:0]                r_data;
    logic                      r_data_rdy;

    ser_state_t                w_state_nxt;
    logic [8*SAMPLE_BYTES-1:0] w_shreg_nxt;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [FS_W-1:0]           w_frame_nxt;
    logic [7:0]                w_data_nxt;
    logic                      w_last_byte;
    logic                      w_capture;
    logic                      w_mark_due;

    // Byte lane for a logical index; MSB-first mirrors the index
    function automatic logic [7:0] sel_byte(
        input logic [8*SAMPLE_BYTES-1:0] v,
        input logic [IDX_W-1:0]          idx
    );
        logic [IDX_W-1:0] pidx;
        logic [7:0]       b;
        pidx = LSB_FIRST ? idx : (IDX_LAST - idx);
        b    = 8'h00;
        for (int i = 0; i < SAMPLE_BYTES; i++) begin
            b = (pidx == IDX_W'(i)) ? v[8*i +: 8] : b;
        end
        return b;
    endfunction

    function automatic logic [FS_W-1:0] frame_advance(input logic [FS_W-1:0] cnt);
        logic [FS_W-1:0] n;
        if (FRAME_SAMPLES == 0) begin
            n = FS_W'(0);
        end else if (cnt == FS_W'(FS_LAST)) begin
            n = FS_W'(0);
        end else begin
            n = cnt + FS_W'(1);
        end
        return n;
    endfunction

    assign w_last_byte = (r_state == SEND) && (r_byte_idx == IDX_LAST) && data_ack;
    assign w_capture   = !reset && sample_rdy && ((r_state == IDLE) || w_last_byte);
    assign w_mark_due  = (FRAME_SAMPLES > 0) && (r_frame_cnt == FS_W'(0));
    assign sample_ack  = w_capture;

    // Next-state and next-output-byte decode
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_idx_nxt   = r_byte_idx;
        w_frame_nxt = r_frame_cnt;
        w_data_nxt  = r_data;
        if (w_capture) begin
            w_shreg_nxt = sample;
            w_idx_nxt   = IDX_W'(0);
            w_frame_nxt = frame_advance(r_frame_cnt);
            if (w_mark_due) begin
                w_state_nxt = MARK;
                w_data_nxt  = MARKER;
            end else begin
                w_state_nxt = SEND;
                w_data_nxt  = sel_byte(sample, IDX_W'(0));
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                MARK: begin
                    if (data_ack) begin
                        w_state_nxt = SEND;
                        w_data_nxt  = sel_byte(r_shreg, r_byte_idx);
                    end else begin
                        w_state_nxt = MARK;
                    end
                end
                SEND: begin
                    if (data_ack) begin
                        if (r_byte_idx == IDX_LAST) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_idx_nxt  = r_byte_idx + IDX_W'(1);
                            w_data_nxt = sel_byte(r_shreg, r_byte_idx + IDX_W'(1));
                        end
                    end else begin
                        w_state_nxt = SEND;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_byte_idx  <= IDX_W'(0);
            r_frame_cnt <= FS_W'(0);
            r_data      <= 8'h00;
            r_data_rdy  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_byte_idx  <= w_idx_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_data      <= w_data_nxt;
            r_data_rdy  <= (w_state_nxt != IDLE);
        end
    end

    assign data_rdy = r_data_rdy;
    assign data     = r_data;

    sat_counter #(
        .W(CNT_W)
    ) u_sample_count (
        .clk  (clk),
        .reset(reset),
        .inc  (w_capture),
        .clr  (count_clr),
        .q    (sample_count)
    );

endmodule

// File: doc/sample_serializer.md
# sample_serializer

Parametrised successor to the FX2-side sample multiplexer. Takes fixed-width timetag samples from the show-ahead sample FIFO and emits them one byte at a time over a `data_rdy`/`data_ack` handshake. New over the previous generation:
- configurable sample width and byte order;
- optional in-band frame marker every N samples;
- integrated saturating sample counter with clear, so the host can check stream length.

Sits between `sample_fifo` (read side) and the FX2 slave FIFO interface, all on `fx2_clk`.

## Interface

Parameters:
- `SAMPLE_BYTES`, default 6: bytes per sample; legal range 1–16.
- `LSB_FIRST`, default 1: 1 emits byte 0 (`sample[7:0]`) first; 0 emits the top byte first.
- `FRAME_SAMPLES`, default 0: 0 disables markers; N>0 emits `MARKER` before every N-th sample, starting with the first after reset.
- `MARKER`, default 8'hA5: marker byte value.
- `CNT_W`, default 16: width of `sample_count`.

Ports:
- `clk`  in  1: `fx2_clk` domain clock.
- `reset`  in  1: synchronous, active-high reset.
- `sample_rdy`  in  1: FIFO non-empty; `sample` is valid (show-ahead).
- `sample`  in  8*SAMPLE_BYTES: head-of-FIFO sample.
- `sample_ack`  out  1: one-cycle read request; `sample` is captured on this edge.
- `data_rdy`  out  1: `data` is valid.
- `data`  out  8: output byte.
- `data_ack`  in  1: host consumes `data` on any edge where `data_rdy & data_ack` is high.
- `count_clr`  in  1: synchronous clear of `sample_count`.
- `sample_count`  out  CNT_W: samples captured since the last clear or reset; saturating.

## Operation

- FSM states: IDLE, MARK, SEND. Registers:
  - `shreg` (8*SAMPLE_BYTES),
  - `byte_idx` (clog2(SAMPLE_BYTES), min 1 bit),
  - `frame_cnt` (clog2(FRAME_SAMPLES), or unused when 0).
- Capture condition: `sample_ack = sample_rdy & (state==IDLE | last_byte_done)`, where `last_byte_done = state==SEND & byte_idx==SAMPLE_BYTES-1 & data_ack`. This signal is combinational and drives FIFO `rdreq` directly.
- On capture:
  - load `shreg`, clear `byte_idx`;
  - `frame_cnt` advances mod FRAME_SAMPLES;
  - next state is MARK if FRAME_SAMPLES>0 and pre-increment `frame_cnt==0`, otherwise SEND.
- Last byte acked with no `sample_rdy` → IDLE.
- MARK: `data=MARKER`, `data_rdy=1`. On `data_ack` → SEND.
- SEND: `data` is the selected byte of `shreg` per `LSB_FIRST`; `data_rdy=1`. On `data_ack` with bytes remaining, `byte_idx` increments.
- `data_rdy` is 0 only in IDLE. `data` holds its last value in IDLE; the value is don't-care.
- `data_ack` without `data_rdy` is ignored.
- `sample_count`:
  - +1 on each `sample_ack`; holds at all-ones.
  - `count_clr` alone → 0.
  - `count_clr` together with `sample_ack` → 1.
- Reset values: state IDLE, `data_rdy=0`, `data=0`, `sample_ack=0`, `sample_count=0`, `frame_cnt=0`, `byte_idx=0`. Reset mid-sample drops the partial sample; no further bytes of it are emitted.

## Timing

- Capture at edge t → `data_rdy=1` with the first byte (or `MARKER`) from t+1.
- Sustained throughput: one byte per cycle while `data_ack` is held high. No bubble between consecutive samples when `sample_rdy` stays high: the last byte of sample k and the first byte (or marker) of sample k+1 are on adjacent cycles.
- `sample_count` updates on the capture edge and is visible at t+1.
- `reset` overrides all other inputs including `count_clr`.

## Structure

- Shared package `timetag_pkg` holds the state enum `ser_state_t` (IDLE/MARK/SEND) and `DEFAULT_MARKER = 8'hA5`.
- One sub-module, `sat_counter` (params `W`; ports `clk`, `reset`, `inc`, `clr`, `q`). It implements `sample_count`, and the summator replacement can reuse it.
- Byte select is a mux on `byte_idx`; the index is mirrored when `LSB_FIRST=0`.

## Test plan

- Default params, `sample=48'hFEEDDEADBEED`, one `sample_rdy` pulse, `data_ack` tied 1 → bytes ED,BE,AD,DE,ED,FE on 6 consecutive cycles starting t+1; `sample_ack` high exactly 1 cycle; `sample_count=1`.
- `LSB_FIRST=0`, same sample → FE,ED,DE,AD,BE,ED.
- `FRAME_SAMPLES=2`, 4 back-to-back samples, ack always high:
  - output is A5, 6 bytes, 6 bytes, A5, 6 bytes, 6 bytes;
  - 26 bytes total with no gap cycles;
  - `sample_count=4`.
- `data_ack` toggled 1,0,1,0… → each byte held stable until acked; 12 cycles per sample; no `sample_ack` until the 6th byte is acked.
- `CNT_W=4`:
  - 20 samples → `sample_count` saturates at 15;
  - `count_clr` coincident with a capture → 1;
  - `count_clr` alone → 0.
- Assert `reset` after 3 bytes of a sample → next cycle `data_rdy=0`, `sample_count=0`. The next sample starts with byte 0, preceded by `MARKER` if framing is enabled.
